// File: rtl/tpu_pkg.sv
// Shared definitions for the micro-TPU: array dimension defaults,
// host opcodes and the host loader state encoding.
package tpu_pkg;

    localparam int N_DEF  = 2;
    localparam int DW_DEF = 8;
    localparam int RW_DEF = 16;

    typedef enum logic [1:0] {
        OP_LOAD_W = 2'b00,
        OP_LOAD_A = 2'b01,
        OP_RUN    = 2'b10,
        OP_READ   = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FETCH  = 3'd4,
        ST_LATCH  = 3'd5,
        ST_OUT_LO = 3'd6,
        ST_OUT_HI = 3'd7
    } loader_state_e;

endpackage

// File: rtl/tpu_result_serializer.sv
// Result holding register and low/high byte selection for the output pins.
module tpu_result_serializer
    import tpu_pkg::*;
#(
    parameter int RW = RW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              latch_i,
    input  logic              valid_i,
    input  logic              sel_hi_i,
    input  logic [RW-1:0]     res_data_i,
    output logic [RW/2-1:0]   out_data_o
);

    logic [RW-1:0] hold_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (ena && latch_i) begin
            hold_q <= res_data_i;
        end
    end

    // The output bus idles at zero so the host never sees a stale result byte.
    always_comb begin
        out_data_o = '0;
        if (valid_i) begin
            out_data_o = sel_hi_i ? hold_q[RW-1:RW/2] : hold_q[RW/2-1:0];
        end
    end

endmodule

// File: rtl/tpu_host_loader.sv
// Byte-serial host front end: parses header bytes, fills the operand buffers,
// launches the array and streams 16-bit results back as low/high byte pairs.
module tpu_host_loader
    import tpu_pkg::*;
#(
    parameter  int N  = N_DEF,
    parameter  int DW = DW_DEF,
    parameter  int RW = RW_DEF,
    localparam int AW = $clog2(N*N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          w_we,
    output logic          a_we,
    output logic [AW-1:0] buf_addr,
    output logic [DW-1:0] buf_data,
    output logic          start,
    input  logic          done,
    output logic [AW-1:0] res_addr,
    input  logic [RW-1:0] res_data,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
);

    localparam logic [AW-1:0] LAST = AW'(N*N-1);

    loader_state_e state_q, state_d;
    logic [AW-1:0] count_q, count_d;
    logic          tgt_act_q, tgt_act_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;

    logic in_hs;
    logic out_hs;

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_OUT_LO) || (state_q == ST_OUT_HI);
    assign busy      = (state_q != ST_IDLE);
    assign in_hs     = in_valid && in_ready && ena;
    assign out_hs    = out_valid && out_ready && ena;

    // A pending write survives ena low and is released on the first enabled cycle.
    assign w_we     = pend_q && !tgt_act_q && ena;
    assign a_we     = pend_q &&  tgt_act_q && ena;
    assign buf_addr = addr_q;
    assign buf_data = data_q;
    assign start    = (state_q == ST_START) && ena;
    assign res_addr = count_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        state_d   = state_q;
        count_d   = count_q;
        tgt_act_d = tgt_act_q;
        pend_d    = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        case (state_q)
            ST_IDLE: begin
                if (in_hs) begin
                    count_d = '0;
                    case (opcode_e'(in_data[7:6]))
                        OP_LOAD_W: begin tgt_act_d = 1'b0; state_d = ST_LOAD;  end
                        OP_LOAD_A: begin tgt_act_d = 1'b1; state_d = ST_LOAD;  end
                        OP_RUN:    state_d = ST_START;
                        OP_READ:   state_d = ST_FETCH;
                    endcase
                end
            end
            ST_LOAD: begin
                if (in_hs) begin
                    pend_d = 1'b1;
                    addr_d = count_q;
                    data_d = in_data[DW-1:0];
                    if (count_q == LAST) begin
                        count_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        count_d = count_q + AW'(1);
                    end
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (done) state_d = ST_IDLE;
            ST_FETCH: state_d = ST_LATCH;
            ST_LATCH: state_d = ST_OUT_LO;
            ST_OUT_LO: if (out_hs) state_d = ST_OUT_HI;
            ST_OUT_HI: begin
                if (out_hs) begin
                    if (count_q == LAST) begin
                        count_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        count_d = count_q + AW'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; ena low freezes everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            tgt_act_q <= 1'b0;
            pend_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else if (ena) begin
            state_q   <= state_d;
            count_q   <= count_d;
            tgt_act_q <= tgt_act_d;
            pend_q    <= pend_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    tpu_result_serializer #(.RW(RW)) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .latch_i    (state_q == ST_LATCH),
        .valid_i    (out_valid),
        .sel_hi_i   (state_q == ST_OUT_HI),
        .res_data_i (res_data),
        .out_data_o (out_data)
    );

endmodule
